boot_page_reader: RTL and testbench
===================================

BOOT_PAGE_READER -- requirements
Module: boot_page_reader

Interface
REQ-001 Parameter HDR_ADDR, default 25'h1FF_FFF0: flash word address of the boot header (magic word; the page word sits at HDR_ADDR+1).
REQ-002 Parameter T_ACC, default 6: clock cycles that CE#/OE# are held low per word read (120 ns at 50 MHz); legal range 2..15.
REQ-003 Parameter MAGIC, default 16'hA55A: header validity word.
REQ-004 Parameter MAX_RETRY, default 3: number of header re-reads after a failed magic check.
REQ-005 clkin_50  in  1  sole clock, rising edge.
REQ-006 sys_resetn  in  1  asynchronous active-low reset.
REQ-007 rd_req  in  1  level request from the top-level boot FSM; a rising edge starts a header read.
REQ-008 pfl_owns_bus  in  1  high while the PFL owns the flash bus; the block must stay off the bus.
REQ-009 fsm_d_in  in  16  flash data bus input.
REQ-010 fsm_a  out  25  flash word address [25:1].
REQ-011 flash_cen, flash_oen, flash_wen, flash_advn  out  1 each  active-low flash strobes.
REQ-012 flash_clk  out  1  held 0 (asynchronous mode).
REQ-013 pfl_str  out  2  selected configuration page (0..2).
REQ-014 wr_done  out  1  level; header read finished and pfl_str is valid.
REQ-015 hdr_err  out  1  level; magic check failed after all retries, or the page value was invalid.
REQ-016 busy  out  1  high in any state other than IDLE, DONE or ERR.

Function
REQ-017 FSM states: IDLE, SETUP, RD_MAG, GAP, RD_PAGE, CHECK, DONE, ERR.
REQ-018 IDLE -> SETUP on a rising edge of rd_req (registered rd_req compared with its previous value) while pfl_owns_bus=0.
REQ-019 SETUP: one cycle; fsm_a=HDR_ADDR, cen/oen high.
REQ-020 RD_MAG: cen=oen=0 for exactly T_ACC cycles; fsm_d_in is captured on the last cycle; -> GAP.
REQ-021 GAP: one cycle with cen=oen=1; fsm_a=HDR_ADDR+1; -> RD_PAGE.
REQ-022 RD_PAGE: same timing as RD_MAG; captures the page word; -> CHECK.
REQ-023 CHECK, magic matches and page[1:0] is in 0..2: pfl_str <= page[1:0]; -> DONE.
REQ-024 CHECK, magic matches and page[1:0]=3: pfl_str <= 0; hdr_err=1; -> DONE.
REQ-025 CHECK, magic mismatch and retry count < MAX_RETRY: increment the count; -> SETUP.
REQ-026 CHECK, magic mismatch and retries exhausted: pfl_str <= 0; hdr_err=1; -> ERR.
REQ-027 DONE and ERR: wr_done=1, held until rd_req=0, then -> IDLE with wr_done=0; hdr_err and pfl_str keep their values until the next start.
REQ-028 Start clears hdr_err and the retry count; pfl_str keeps its old value until CHECK.
REQ-029 flash_wen=1 and flash_advn=0 at all times; no write cycle is ever issued.
REQ-030 Abort: pfl_owns_bus=1 or rd_req=0 in any busy state -> IDLE on the next cycle.
  - cen/oen go high in that same next cycle.
  - wr_done stays 0; pfl_str is unchanged.
REQ-031 Simultaneous rd_req rise and pfl_owns_bus=1: the start is ignored.
REQ-032 Outside RD_MAG/RD_PAGE: cen=oen=1; fsm_a holds its last value.
REQ-033 All strobes come directly from flip-flops (glitch-free).
REQ-034 Address arithmetic is 25-bit unsigned; HDR_ADDR+1 wraps modulo 2^25.
REQ-035 Header read latency with no retries: 2*T_ACC+3 cycles from the registered rd_req edge to wr_done=1.

Reset
REQ-036 While sys_resetn=0: state=IDLE; cen=oen=wen=1; advn=0; flash_clk=0; fsm_a=0; pfl_str=0; wr_done=0; hdr_err=0; busy=0; retry count=0; rd_req history=1.
  - History=1 means a request held high through reset does not start a read; a fresh rising edge is needed.
REQ-037 Reset asserted mid-read: all outputs take their reset values immediately (asynchronously).

Structure
REQ-038 The shared package holds: state encoding, MAGIC default, HDR_ADDR default, page-code constants (PAGE_FACTORY=0, PAGE_USER1=1, PAGE_USER2=2).
REQ-039 One sub-module: flash_rd_timer, a T_ACC down-counter with load/expire, instantiated once and reused by both read states.

Verification
REQ-040 Flash model returns A55A, 0001; pulse rd_req -> pfl_str=1, wr_done=1 at cycle 15, hdr_err=0, exactly two OE# pulses of 6 cycles.
REQ-041 Magic returns 0000 four times -> 4 header reads, pfl_str=0, hdr_err=1, state ERR, wr_done=1.
REQ-042 Magic A55A, page 0003 -> pfl_str=0, hdr_err=1, wr_done=1.
REQ-043 pfl_owns_bus rises on the 3rd RD_MAG cycle -> cen/oen high next cycle, busy=0, wr_done=0; a later rd_req edge completes normally.
REQ-044 rd_req held high through reset release -> no flash access; drop and re-raise -> read occurs.
REQ-045 sys_resetn asserted during RD_PAGE -> all outputs at reset values in the same cycle; pfl_str=0.

Source files
------------

// File: rtl/boot_page_reader_pkg.sv
// boot_page_reader_pkg: shared types and constants for the boot
// header reader (state encoding, header defaults, page codes).
package boot_page_reader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_RD_MAG,
    S_GAP,
    S_RD_PAGE,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [15:0] MAGIC_DEF    = 16'hA55A;
  localparam logic [24:0] HDR_ADDR_DEF = 25'h1FF_FFF0;

  localparam logic [1:0] PAGE_FACTORY = 2'd0;
  localparam logic [1:0] PAGE_USER1   = 2'd1;
  localparam logic [1:0] PAGE_USER2   = 2'd2;

  function automatic logic is_busy(state_e s);
    return !(s inside {S_IDLE, S_DONE, S_ERR});
  endfunction

  function automatic logic is_read(state_e s);
    return s inside {S_RD_MAG, S_RD_PAGE};
  endfunction

endpackage

// File: rtl/boot_page_reader_if.sv
// boot_page_reader_if: asynchronous parallel-flash bus.
// master = reader (address/strobes out, data in); slave = flash.
interface boot_page_reader_if;

  logic [24:0] fsm_a;
  logic [15:0] fsm_d_in;
  logic        flash_cen;
  logic        flash_oen;
  logic        flash_wen;
  logic        flash_advn;
  logic        flash_clk;

  modport master (
    output fsm_a,
    output flash_cen,
    output flash_oen,
    output flash_wen,
    output flash_advn,
    output flash_clk,
    input  fsm_d_in
  );

  modport slave (
    input  fsm_a,
    input  flash_cen,
    input  flash_oen,
    input  flash_wen,
    input  flash_advn,
    input  flash_clk,
    output fsm_d_in
  );

endinterface

// File: rtl/boot_page_reader_flash_rd_timer.sv
// flash_rd_timer: access-time down-counter shared by both read states.
// Ports: clk_i/rst_ni; load_i arms T_ACC; en_i counts; expire_o = last cycle.
module flash_rd_timer #(
  parameter int unsigned T_ACC = 6
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  // Loaded one cycle before the strobe drops, so the count reaches
  // zero on exactly the T_ACC-th low cycle.
  localparam logic [3:0] LOAD_VAL = 4'(T_ACC - 1);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (en_i && cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && (cnt_q == 4'd0);

endmodule

// File: rtl/boot_page_reader.sv
// boot_page_reader: reads magic + page words of the boot header from
// flash and publishes the selected configuration page.
// Ports: clkin_50, sys_resetn (async low); rd_req start level;
// pfl_owns_bus lockout; flash (if master); pfl_str, wr_done,
// hdr_err, busy status outputs.
module boot_page_reader
  import boot_page_reader_pkg::*;
#(
  parameter logic [24:0] HDR_ADDR  = HDR_ADDR_DEF,
  parameter int unsigned T_ACC     = 6,
  parameter logic [15:0] MAGIC     = MAGIC_DEF,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic               clkin_50,
  input  logic               sys_resetn,
  input  logic               rd_req,
  input  logic               pfl_owns_bus,
  boot_page_reader_if.master flash,
  output logic [1:0]         pfl_str,
  output logic               wr_done,
  output logic               hdr_err,
  output logic               busy
);

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [24:0] PAGE_ADDR = HDR_ADDR + 25'd1;

  state_e state_q, state_d;

  logic          req_q, req_hist_q;
  logic [RW-1:0] retry_q, retry_d;
  logic [15:0]   mag_q, mag_d;
  logic [1:0]    page_q, page_d;
  logic [24:0]   addr_q, addr_d;
  logic          cen_q, oen_q, strb_d;
  logic [1:0]    str_q, str_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;

  logic rise, abort;
  logic mag_ok, page_ok, retry_left;
  logic tmr_load, tmr_en, tmr_exp;

  assign rise       = req_q & ~req_hist_q;
  assign abort      = pfl_owns_bus | ~rd_req;
  assign mag_ok     = (mag_q == MAGIC);
  assign retry_left = (retry_q < RW'(MAX_RETRY));

  always_comb begin
    page_ok = 1'b0;
    unique case (page_q)
      PAGE_FACTORY,
      PAGE_USER1,
      PAGE_USER2: page_ok = 1'b1;
      default:    page_ok = 1'b0;
    endcase
  end

  // Timer is armed in the cycle before either read window.
  assign tmr_load = (state_q == S_SETUP) || (state_q == S_GAP);
  assign tmr_en   = is_read(state_q);

  flash_rd_timer #(
    .T_ACC (T_ACC)
  ) u_tmr (
    .clk_i    (clkin_50),
    .rst_ni   (sys_resetn),
    .load_i   (tmr_load),
    .en_i     (tmr_en),
    .expire_o (tmr_exp)
  );

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    mag_d   = mag_q;
    page_d  = page_q;
    str_d   = str_q;
    err_d   = err_q;
    if (is_busy(state_q) && abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (rise && !pfl_owns_bus) begin
            state_d = S_SETUP;
            retry_d = '0;
            err_d   = 1'b0;
          end
        end
        S_SETUP: state_d = S_RD_MAG;
        S_RD_MAG: begin
          if (tmr_exp) begin
            mag_d   = flash.fsm_d_in;
            state_d = S_GAP;
          end
        end
        S_GAP: state_d = S_RD_PAGE;
        S_RD_PAGE: begin
          if (tmr_exp) begin
            page_d  = flash.fsm_d_in[1:0];
            state_d = S_CHECK;
          end
        end
        S_CHECK: begin
          unique case (1'b1)
            mag_ok && page_ok: begin
              str_d   = page_q;
              state_d = S_DONE;
            end
            mag_ok && !page_ok: begin
              str_d   = PAGE_FACTORY;
              err_d   = 1'b1;
              state_d = S_DONE;
            end
            !mag_ok && retry_left: begin
              retry_d = retry_q + RW'(1);
              state_d = S_SETUP;
            end
            default: begin
              str_d   = PAGE_FACTORY;
              err_d   = 1'b1;
              state_d = S_ERR;
            end
          endcase
        end
        S_DONE,
        S_ERR: begin
          if (!rd_req) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Strobes/status are registered from the next state so every
  // output pin comes straight from a flop.
  assign strb_d = ~is_read(state_d);
  assign done_d = (state_d == S_DONE) || (state_d == S_ERR);
  assign busy_d = is_busy(state_d);

  always_comb begin
    addr_d = addr_q;
    if (state_d == S_SETUP) begin
      addr_d = HDR_ADDR;
    end else if (state_d == S_GAP) begin
      addr_d = PAGE_ADDR;
    end
  end

  always_ff @(posedge clkin_50 or negedge sys_resetn) begin
    if (!sys_resetn) begin
      state_q    <= S_IDLE;
      req_q      <= 1'b1;
      req_hist_q <= 1'b1;
      retry_q    <= '0;
      mag_q      <= 16'd0;
      page_q     <= 2'd0;
      addr_q     <= 25'd0;
      cen_q      <= 1'b1;
      oen_q      <= 1'b1;
      str_q      <= PAGE_FACTORY;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= rd_req;
      req_hist_q <= req_q;
      retry_q    <= retry_d;
      mag_q      <= mag_d;
      page_q     <= page_d;
      addr_q     <= addr_d;
      cen_q      <= strb_d;
      oen_q      <= strb_d;
      str_q      <= str_d;
      done_q     <= done_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  assign flash.fsm_a      = addr_q;
  assign flash.flash_cen  = cen_q;
  assign flash.flash_oen  = oen_q;
  assign flash.flash_wen  = 1'b1;
  assign flash.flash_advn = 1'b0;
  assign flash.flash_clk  = 1'b0;

  assign pfl_str = str_q;
  assign wr_done = done_q;
  assign hdr_err = err_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_boot_page_reader.sv
// tb_boot_page_reader: directed + randomized header reads against a
// list-based reference model and a timed flash model.
module tb_boot_page_reader;
  import boot_page_reader_pkg::*;

  localparam int          T    = 6;
  localparam int          MR   = 3;
  localparam logic [24:0] HDR  = HDR_ADDR_DEF;
  localparam logic [15:0] MG   = MAGIC_DEF;
  localparam int          LAT1 = 2 * T + 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rd_req;
  logic       owns;
  logic [1:0] pfl_str;
  logic       wr_done, hdr_err, busy;

  boot_page_reader_if bus();

  boot_page_reader #(
    .HDR_ADDR  (HDR),
    .T_ACC     (T),
    .MAGIC     (MG),
    .MAX_RETRY (MR)
  ) dut (
    .clkin_50     (clk),
    .sys_resetn   (rst_n),
    .rd_req       (rd_req),
    .pfl_owns_bus (owns),
    .flash        (bus),
    .pfl_str      (pfl_str),
    .wr_done      (wr_done),
    .hdr_err      (hdr_err),
    .busy         (busy)
  );

  always #10 clk = ~clk;

  int n_run;
  int n_fail;

  // Flash model: data valid only on the last cycle of a T-cycle access.
  logic [15:0] mseq [4];
  logic [15:0] pval;
  logic [15:0] fd;
  int          mbase;
  int          kidx;
  int          lowcnt, pulses, mag_rd, bad_len, viol;
  logic        oen_p = 1'b1;

  always @(posedge clk) begin
    oen_p  <= bus.flash_oen;
    lowcnt <= bus.flash_oen ? 0 : lowcnt + 1;
    if (bus.flash_oen && lowcnt != 0) begin
      pulses <= pulses + 1;
      if (lowcnt != T) bad_len <= bad_len + 1;
    end
    if (oen_p && !bus.flash_oen && bus.fsm_a == HDR)
      mag_rd <= mag_rd + 1;
    if (bus.flash_cen !== bus.flash_oen || bus.flash_wen !== 1'b1 ||
        bus.flash_advn !== 1'b0 || bus.flash_clk !== 1'b0)
      viol <= viol + 1;
  end

  always_comb begin
    kidx = mag_rd - mbase - 1;
    if (kidx < 0) kidx = 0;
    if (kidx > 3) kidx = 3;
    fd = 16'hBAD0;
    if (!bus.flash_cen && !bus.flash_oen && lowcnt == T - 1) begin
      if (bus.fsm_a == HDR) fd = mseq[kidx];
      else if (bus.fsm_a == HDR + 25'd1) fd = pval;
    end
  end

  assign bus.fsm_d_in = fd;

  logic [1:0] exp_str;
  logic       exp_err;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Scan the magic sequence: first matching attempt wins, else give up
  // after 1+MR attempts.
  function automatic void ref_model(output int nrd, output logic [1:0] str,
                                    output logic err);
    nrd = 0;
    str = 2'd0;
    err = 1'b1;
    for (int i = 0; i <= MR; i++) begin
      nrd = i + 1;
      if (mseq[i] == MG) begin
        err = (pval[1:0] == 2'd3);
        str = err ? 2'd0 : pval[1:0];
        return;
      end
    end
  endfunction

  task automatic wait_busy(input string tag);
    int w;
    w = 0;
    while (!busy && w < 10) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_busy"}, busy, 1);
  endtask

  task automatic run_txn(input string tag);
    int n_exp, p0, m0, b0, v0, lat;
    logic [1:0] s_exp;
    logic e_exp;
    ref_model(n_exp, s_exp, e_exp);
    p0 = pulses; m0 = mag_rd; b0 = bad_len; v0 = viol;
    mbase = mag_rd;
    @(negedge clk);
    rd_req = 1'b1;
    wait_busy(tag);
    check({tag, "_str_held"}, pfl_str, exp_str);
    check({tag, "_err_clr"}, hdr_err, 0);
    lat = 0;
    while (!wr_done && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, lat, n_exp * LAT1);
    check({tag, "_str"}, pfl_str, s_exp);
    check({tag, "_err"}, hdr_err, e_exp);
    check({tag, "_idle"}, busy, 0);
    check({tag, "_pulses"}, pulses - p0, 2 * n_exp);
    check({tag, "_hdr_rd"}, mag_rd - m0, n_exp);
    check({tag, "_plen"}, bad_len - b0, 0);
    check({tag, "_strobes"}, viol - v0, 0);
    repeat (3) @(negedge clk);
    check({tag, "_done_hold"}, wr_done, 1);
    rd_req = 1'b0;
    @(negedge clk);
    check({tag, "_done_drop"}, wr_done, 0);
    check({tag, "_str_keep"}, pfl_str, s_exp);
    check({tag, "_err_keep"}, hdr_err, e_exp);
    exp_str = s_exp;
    exp_err = e_exp;
  endtask

  task automatic chk_reset_vals(input string tag);
    check({tag, "_cen"}, bus.flash_cen, 1);
    check({tag, "_oen"}, bus.flash_oen, 1);
    check({tag, "_wen"}, bus.flash_wen, 1);
    check({tag, "_advn"}, bus.flash_advn, 0);
    check({tag, "_fclk"}, bus.flash_clk, 0);
    check({tag, "_addr"}, bus.fsm_a, 0);
    check({tag, "_str"}, pfl_str, 0);
    check({tag, "_done"}, wr_done, 0);
    check({tag, "_err"}, hdr_err, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired tests=%0d", n_run);
    $fatal(1);
  end

  initial begin
    int nb, p0;
    logic [15:0] v;
    rst_n   = 1'b0;
    rd_req  = 1'b1;
    owns    = 1'b0;
    mbase   = 0;
    mseq    = '{MG, MG, MG, MG};
    pval    = 16'h0001;
    exp_str = 2'd0;
    exp_err = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");

    // Request held through reset release must not start a read.
    rst_n = 1'b1;
    p0 = pulses;
    repeat (30) @(negedge clk);
    check("held_req_pulses", pulses - p0, 0);
    check("held_req_busy", busy, 0);
    rd_req = 1'b0;
    repeat (2) @(negedge clk);

    mseq = '{MG, MG, MG, MG};
    pval = 16'h0001;
    run_txn("basic");

    mseq = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
    pval = 16'h0001;
    run_txn("all_bad");

    mseq = '{MG, MG, MG, MG};
    pval = 16'h0003;
    run_txn("page3");

    mseq = '{16'h1234, MG, MG, MG};
    pval = 16'h0002;
    run_txn("retry1");

    // Bus taken away on the third magic-read cycle.
    mbase = mag_rd;
    @(negedge clk);
    rd_req = 1'b1;
    wait_busy("own_abort");
    repeat (3) @(negedge clk);
    check("own_abort_oen_low", bus.flash_oen, 0);
    owns = 1'b1;
    @(negedge clk);
    check("own_abort_cen", bus.flash_cen, 1);
    check("own_abort_oen", bus.flash_oen, 1);
    check("own_abort_busy", busy, 0);
    check("own_abort_done", wr_done, 0);
    check("own_abort_str", pfl_str, exp_str);
    repeat (3) @(negedge clk);
    rd_req = 1'b0;
    owns   = 1'b0;
    @(negedge clk);
    mseq = '{MG, MG, MG, MG};
    pval = 16'h0001;
    run_txn("after_abort");

    // Request dropped during the page read.
    mbase = mag_rd;
    @(negedge clk);
    rd_req = 1'b1;
    wait_busy("req_abort");
    repeat (8) @(negedge clk);
    check("req_abort_in_page", bus.fsm_a, HDR + 25'd1);
    rd_req = 1'b0;
    @(negedge clk);
    check("req_abort_busy", busy, 0);
    check("req_abort_oen", bus.flash_oen, 1);
    check("req_abort_done", wr_done, 0);
    check("req_abort_str", pfl_str, exp_str);

    // Rising request while the bus is owned is ignored.
    @(negedge clk);
    rd_req = 1'b1;
    owns   = 1'b1;
    repeat (4) @(negedge clk);
    owns = 1'b0;
    p0 = pulses;
    repeat (20) @(negedge clk);
    check("owned_start_busy", busy, 0);
    check("owned_start_pulses", pulses - p0, 0);
    rd_req = 1'b0;
    repeat (2) @(negedge clk);

    for (int t = 0; t < 24; t++) begin
      nb = $urandom_range(0, MR + 1);
      for (int i = 0; i <= MR; i++) begin
        v = 16'($urandom);
        if (v == MG) v = ~v;
        mseq[i] = (i < nb) ? v : MG;
      end
      pval = 16'($urandom);
      run_txn("rand");
    end

    mseq = '{MG, MG, MG, MG};
    pval = 16'h0002;
    run_txn("pre_rst");

    // Asynchronous reset in the middle of the page read.
    @(negedge clk);
    rd_req = 1'b1;
    wait_busy("mid_rst");
    repeat (10) @(negedge clk);
    check("mid_rst_oen_low", bus.flash_oen, 0);
    check("mid_rst_addr", bus.fsm_a, HDR + 25'd1);
    #3 rst_n = 1'b0;
    #1;
    chk_reset_vals("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    exp_str = 2'd0;
    repeat (2) @(negedge clk);
    p0 = pulses;
    repeat (20) @(negedge clk);
    check("post_rst_pulses", pulses - p0, 0);
    check("post_rst_busy", busy, 0);
    rd_req = 1'b0;
    repeat (2) @(negedge clk);
    run_txn("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
